// File: rtl/rev_pe_pkg.sv
// Shared types and constants for the reverse-check PE sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rev_pe_pkg;

    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_PIPE_LAT  = 3;
    localparam int DEF_ERR_STAGE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] STAT_OK    = 2'b00;
    localparam logic [1:0] STAT_ERR   = 2'b01;
    localparam logic [1:0] STAT_ABORT = 2'b10;
    localparam logic [1:0] STAT_HALT  = 2'b11;

    // Run outcome priority: halted > aborted > error seen > ok.
    function automatic logic [1:0] status_enc(input logic halted,
                                              input logic aborted,
                                              input logic err_seen);
        if (halted)
            return STAT_HALT;
        else if (aborted)
            return STAT_ABORT;
        else if (err_seen)
            return STAT_ERR;
        else
            return STAT_OK;
    endfunction

endpackage

// File: rtl/rev_pe_tag_pipe.sv
// Valid/address tag shift register that follows each read through the PE pipeline.
// Latency: stage k holds the tag entered k cycles earlier (stage DEPTH feeds the write).
// Backpressure: none; advances every cycle, the sequencer owns all stalling decisions.
module rev_pe_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int AW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [AW-1:0]            in_addr,
    output logic [DEPTH:1]           stg_vld,
    output logic [DEPTH:1][AW-1:0]   stg_addr
);

    // Shift every tag one stage deeper per cycle; reset empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld  <= '0;
            stg_addr <= '0;
        end else begin
            stg_vld  <= {stg_vld[DEPTH-1:1], in_vld};
            stg_addr <= {stg_addr[DEPTH-1:1], in_addr};
        end
    end

endmodule

// File: rtl/rev_pe_seq_ctrl.sv
// Run sequencer for the reverse-check PE: issues reads, tracks tags, counts check errors.
// Latency: write of address a occurs PIPE_LAT cycles after its read; done one cycle after last write.
// Backpressure: none; abort stops new reads immediately. Optional REV_PE_ERR_HALT_EN halts on first error.
module rev_pe_seq_ctrl
    import rev_pe_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int ERR_STAGE = DEF_ERR_STAGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pipe_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              err1_in,
    input  logic              err2_in,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [1:0]        first_err_src
);

    state_t                           r_state;
    logic [ADDR_W-1:0]                r_len;
    logic [ADDR_W-1:0]                r_rd_addr;
    logic [7:0]                       r_err_cnt;
    logic [ADDR_W-1:0]                r_first_addr;
    logic [1:0]                       r_first_src;
    logic                             r_err_seen;
    logic                             r_aborted;
    logic                             r_halted;

    logic [PIPE_LAT:1]                w_tag_vld;
    logic [PIPE_LAT:1][ADDR_W-1:0]    w_tag_addr;
    logic                             w_err_smp;
    logic                             w_inflight;
    logic                             w_halt;
    logic                             w_stop;
    logic                             w_rd_en;
    logic                             w_last;
    logic                             w_unused_addr;

    // An error only counts when a real item sits at the checking stage.
    assign w_err_smp  = w_tag_vld[ERR_STAGE] && (err1_in || err2_in);
    // Items still upstream of the write stage keep the run in DRAIN.
    assign w_inflight = |w_tag_vld[PIPE_LAT-1:1];
    assign w_last     = (r_rd_addr == r_len);

`ifdef REV_PE_ERR_HALT_EN
    assign w_halt = (r_state == ST_ISSUE) && w_err_smp && !r_err_seen;
`else
    assign w_halt = 1'b0;
`endif

    // Abort (or halt) suppresses the read in the very cycle it is seen.
    assign w_stop  = abort || w_halt;
    assign w_rd_en = (r_state == ST_ISSUE) && !w_stop;

    // Only the checking and write stages need addresses; the rest are intentionally dropped.
    assign w_unused_addr = ^w_tag_addr;

    rev_pe_tag_pipe #(
        .DEPTH (PIPE_LAT),
        .AW    (ADDR_W)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (w_rd_en),
        .in_addr  (r_rd_addr),
        .stg_vld  (w_tag_vld),
        .stg_addr (w_tag_addr)
    );

    // Run FSM plus error bookkeeping; the error fields are only cleared in IDLE where no tag is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_rd_addr    <= '0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_src  <= '0;
            r_err_seen   <= 1'b0;
            r_aborted    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            if (w_err_smp) begin
                if (r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
                if (!r_err_seen) begin
                    r_err_seen   <= 1'b1;
                    r_first_addr <= w_tag_addr[ERR_STAGE];
                    r_first_src  <= {err2_in, err1_in};
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_len        <= len;
                        r_rd_addr    <= '0;
                        r_err_cnt    <= '0;
                        r_first_addr <= '0;
                        r_first_src  <= '0;
                        r_err_seen   <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_halted     <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_stop) begin
                        if (abort)
                            r_aborted <= 1'b1;
                        if (w_halt)
                            r_halted <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else if (w_last) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (abort)
                        r_aborted <= 1'b1;
                    if (!w_inflight)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (abort)
                        r_aborted <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en          = w_rd_en;
    assign rd_addr        = r_rd_addr;
    assign busy           = (r_state != ST_IDLE);
    assign pipe_en        = busy;
    assign done           = (r_state == ST_DONE);
    assign wr_en          = w_tag_vld[PIPE_LAT];
    assign wr_addr        = w_tag_addr[PIPE_LAT];
    assign status         = status_enc(r_halted, r_aborted, r_err_seen);
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_addr;
    assign first_err_src  = r_first_src;

endmodule

// File: tb/tb_rev_pe_seq_ctrl.sv
// Self-checking bench for rev_pe_seq_ctrl: directed and random runs against a run-level model.
// Latency: model predicts read/write/done cycles from item counts.
// Backpressure: abort, halt and ignored-start cases are exercised.
module tb_rev_pe_seq_ctrl;

    localparam int AW = 9;
    localparam int PL = 3;
    localparam int ES = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] len;
    logic          abort;
    logic          err1_in;
    logic          err2_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pipe_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [7:0]    err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [1:0]    first_err_src;

    int n_assert = 0;
    int n_fail   = 0;
    bit e1 [512];
    bit e2 [512];

    always #5 clk = ~clk;

    rev_pe_seq_ctrl #(
        .ADDR_W    (AW),
        .PIPE_LAT  (PL),
        .ERR_STAGE (ES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .len            (len),
        .abort          (abort),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .pipe_en        (pipe_en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .err1_in        (err1_in),
        .err2_in        (err2_in),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_src  (first_err_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_en"}, 32'(rd_en), 0);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".pipe_en"}, 32'(pipe_en), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".status"}, 32'(status), 0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
        chk({tag, ".first_err_addr"}, 32'(first_err_addr), 0);
        chk({tag, ".first_err_src"}, 32'(first_err_src), 0);
        chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
    endtask

    task automatic clear_errs();
        for (int a = 0; a < 512; a++) begin
            e1[a] = 1'b0;
            e2[a] = 1'b0;
        end
    endtask

    // One run: L = len, ac = cycle of abort (0 = none), cycle 0 is the start cycle.
    task automatic run(input string tag, input int L, input int ac, input bit noise_start);
        int  n0, n, d, cnt, first, src, stat, a;
        bit  aborted, halted;
`ifdef REV_PE_ERR_HALT_EN
        int  af, hc, issue_end;
`endif
        n0 = L + 1;
        n  = n0;
        halted = 1'b0;
        if (ac != 0 && ac <= n0)
            n = ac - 1;
`ifdef REV_PE_ERR_HALT_EN
        af = -1;
        for (int i = 0; i < n; i++)
            if ((e1[i] || e2[i]) && af < 0)
                af = i;
        if (af >= 0) begin
            hc = af + 1 + ES;
            issue_end = (ac != 0 && ac <= n0) ? ac : n0;
            if (hc <= issue_end) begin
                halted = 1'b1;
                if (hc - 1 < n)
                    n = hc - 1;
            end
        end
`endif
        d = n + PL + 1;
        aborted = (ac != 0 && ac < d);
        cnt = 0; first = 0; src = 0;
        for (int i = n - 1; i >= 0; i--)
            if (e1[i] || e2[i]) begin
                cnt++;
                first = i;
                src = 2 * int'(e2[i]) + int'(e1[i]);
            end
        if (cnt > 255)
            cnt = 255;
        stat = halted ? 3 : (aborted ? 2 : (cnt > 0 ? 1 : 0));

        for (int c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            start = (c == 0) || (noise_start && c >= 1 && c <= d && $urandom_range(0, 3) == 0);
            len   = (c == 0) ? AW'(L) : AW'($urandom);
            abort = (ac != 0 && c == ac && c < d);
            a = c - 1 - ES;
            if (a >= 0 && a < n) begin
                err1_in = e1[a];
                err2_in = e2[a];
            end else begin
                err1_in = 1'($urandom_range(0, 1));
                err2_in = 1'($urandom_range(0, 1));
            end
            #1;
            chk({tag, ".rd_en"}, 32'(rd_en), 32'(c >= 1 && c <= n));
            if (c >= 1 && c <= n)
                chk({tag, ".rd_addr"}, 32'(rd_addr), c - 1);
            chk({tag, ".wr_en"}, 32'(wr_en), 32'(c >= PL + 1 && c <= PL + n));
            if (c >= PL + 1 && c <= PL + n)
                chk({tag, ".wr_addr"}, 32'(wr_addr), c - PL - 1);
            chk({tag, ".done"}, 32'(done), 32'(c == d));
            chk({tag, ".busy"}, 32'(busy), 32'(c >= 1 && c <= d));
            chk({tag, ".pipe_en"}, 32'(pipe_en), 32'(c >= 1 && c <= d));
            if (c == d) begin
                chk({tag, ".status"}, 32'(status), stat);
                chk({tag, ".err_cnt"}, 32'(err_cnt), cnt);
                if (cnt > 0) begin
                    chk({tag, ".first_err_addr"}, 32'(first_err_addr), first);
                    chk({tag, ".first_err_src"}, 32'(first_err_src), src);
                end
            end
        end
        start   = 1'b0;
        abort   = 1'b0;
        err1_in = 1'b0;
        err2_in = 1'b0;
    endtask

    initial begin
        int L, d0, ac;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        err1_in = 1'b0; err2_in = 1'b0; len = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Basic four-item run, no errors.
        clear_errs();
        run("len3", 3, 0, 1'b0);

        // Single item.
        run("len0", 0, 0, 1'b0);

        // Two errors with distinct sources.
        clear_errs();
        e1[5] = 1'b1;
        e2[9] = 1'b1;
        run("err2", 15, 0, 1'b0);

        // Abort right after address 6 issued.
        clear_errs();
        run("abort_issue", 15, 8, 1'b0);

        // Abort while draining only changes status.
        run("abort_drain", 5, 8, 1'b0);

        // Error at address 4 (halts when the halt option is built in).
        clear_errs();
        e1[4] = 1'b1;
        run("err_at4", 15, 0, 1'b0);

        // start together with abort in IDLE must not start a run.
        clear_errs();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; len = AW'(4);
        #1;
        chk("start_abort.busy0", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        chk("start_abort.busy1", 32'(busy), 0);
        chk("start_abort.rd_en", 32'(rd_en), 0);

        // Error counter saturation, with stray starts during the run.
        for (int a = 0; a < 300; a++) e1[a] = 1'b1;
        run("sat", 299, 0, 1'b1);

        // Full buffer, random error pattern.
        clear_errs();
        for (int a = 0; a < 512; a++) begin
            e1[a] = ($urandom_range(0, 15) == 0);
            e2[a] = ($urandom_range(0, 15) == 0);
        end
        run("full", 511, 0, 1'b0);

        // Random runs.
        for (int r = 0; r < 12; r++) begin
            clear_errs();
            L = $urandom_range(0, 40);
            for (int a = 0; a <= L; a++) begin
                e1[a] = ($urandom_range(0, 7) == 0);
                e2[a] = ($urandom_range(0, 7) == 0);
            end
            d0 = L + 1 + PL + 1;
            ac = 0;
            if ($urandom_range(0, 1) == 1)
                ac = $urandom_range(2, d0 - 1);
            run("rand", L, ac, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run: everything clears, no done, no writes.
        clear_errs();
        @(negedge clk);
        start = 1'b1; len = AW'(15);
        @(negedge clk);
        start = 1'b0; err1_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1; err1_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("midrst.done", 32'(done), 0);
            chk("midrst.wr_en", 32'(wr_en), 0);
            chk("midrst.busy", 32'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
